pc_control: RTL

Program-counter and fetch-redirect stage of the mips32 pipeline, directly downstream of the ID-stage branch compare unit. Holds the PC register, issues instruction-memory fetch requests, and computes and applies the branch/jump target when the compare unit reports a taken branch. Drives the IF/ID flush for the wrong-path instruction, and holds a redirect that arrives while instruction memory is busy.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/branch_target_calc.sv | 48 ++++
 rtl/pc_control.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, target-select encodings and PC-stage state enum
//
// Contents:
//   TGT_REL / TGT_ABS / TGT_REG : target_sel encodings (2'b11 is reserved, decoded as TGT_REL)
//   state_t                     : PC-stage state (ST_BOOT, ST_FETCH, ST_PEND)
//   DEFAULT_RESET_PC            : default reset fetch address

package mips_pkg;

  localparam logic [1:0] TGT_REL = 2'b00;
  localparam logic [1:0] TGT_ABS = 2'b01;
  localparam logic [1:0] TGT_REG = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_PEND  = 2'b10
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational branch/jump target mux and adders
//
// Ports:
//   i_target_sel [1:0]  : 00 PC-relative, 01 absolute jump, 10 register jump, 11 as 00
//   i_id_pc     [31:0]  : PC of the instruction in ID
//   i_imm       [15:0]  : branch offset (words, signed)
//   i_jindex    [25:0]  : jump index field
//   i_rs_value  [31:0]  : forwarded rs value for jr
//   o_target    [31:0]  : selected redirect address (mod 2^32)

module branch_target_calc
  import mips_pkg::*;
(
  input  logic [1:0]  i_target_sel,
  input  logic [31:0] i_id_pc,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_jindex,
  input  logic [31:0] i_rs_value,
  output logic [31:0] o_target
);

  logic [31:0] w_id_pc_plus4;
  logic [31:0] w_offset;
  logic [31:0] w_rel_target;
  logic [31:0] w_abs_target;
  logic [31:0] w_reg_target;
  logic        w_unused_rs_lsb;

  assign w_id_pc_plus4 = i_id_pc + 32'd4;
  // Offset counts words: sign-extend then scale by 4.
  assign w_offset      = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign w_rel_target  = w_id_pc_plus4 + w_offset;
  // Region bits come from the delay-slot address, not the branch itself.
  assign w_abs_target  = {w_id_pc_plus4[31:28], i_jindex, 2'b00};
  // jr forces word alignment by dropping the low two bits.
  assign w_reg_target  = {i_rs_value[31:2], 2'b00};
  assign w_unused_rs_lsb = ^i_rs_value[1:0];

  always_comb begin
    o_target = w_rel_target;
    case (i_target_sel)
      TGT_ABS: o_target = w_abs_target;
      TGT_REG: o_target = w_reg_target;
      default: o_target = w_rel_target;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// rtl/pc_control.sv - PC register, fetch request and branch redirect stage
//
// Parameters:
//   RESET_PC : word-aligned PC loaded on reset
// Configuration macro:
//   BRANCH_DELAY_SLOT_EN : when defined, flush_if_id is tied to 0 (delay-slot
//                          instruction executes); redirect behaviour unchanged
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   stall_i           : hazard hold; PC frozen and ID inputs ignored in FETCH
//   is_branch         : taken branch/jump from the ID compare unit
//   target_sel [1:0]  : target kind (see branch_target_calc)
//   id_pc, imm, jindex, rs_value : target operands from ID
//   imem_ready        : instruction memory accepts the current request
//   imem_req          : fetch request at pc
//   pc, pc_plus4      : current fetch address and pc + 4
//   flush_if_id       : one-cycle IF/ID clear on an accepted redirect

module pc_control
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        is_branch,
  input  logic [1:0]  target_sel,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm,
  input  logic [25:0] jindex,
  input  logic [31:0] rs_value,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush_if_id
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_target;
  logic        r_imem_req;

  logic [31:0] w_target;
  logic        w_redirect;

  branch_target_calc u_target (
    .i_target_sel (target_sel),
    .i_id_pc      (id_pc),
    .i_imm        (imm),
    .i_jindex     (jindex),
    .i_rs_value   (rs_value),
    .o_target     (w_target)
  );

  // A stalled ID stage may hold stale compare results, so is_branch only counts when not stalled.
  assign w_redirect = is_branch && !stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_pend_target <= 32'h0000_0000;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (w_redirect && imem_ready) begin
            r_pc <= w_target;
          end else if (w_redirect) begin
            // Memory busy: keep presenting the old address, remember where to go.
            r_pend_target <= w_target;
            r_state       <= ST_PEND;
          end else if (imem_ready && !stall_i) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        ST_PEND: begin
          // First redirect wins; stall_i and later is_branch are ignored here.
          if (imem_ready) begin
            r_pc    <= r_pend_target;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign imem_req = r_imem_req;
  assign pc       = r_pc;
  assign pc_plus4 = r_pc + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
  assign flush_if_id = 1'b0;
`else
  // Flush on the edge that accepts the redirect, whether immediate or pending.
  assign flush_if_id = ((r_state == ST_FETCH) && w_redirect && imem_ready) ||
                       ((r_state == ST_PEND) && imem_ready);
`endif

endmodule
